spi_frame_rx: RTL
=================

// Module: spi_frame_rx
// PURPOSE
//   Oversampled SPI (mode 0, MSB first) receiver for the global job bus (sck0/sdi0/cs0_n).
//   Sits between the board pins and the miner core, in the PLL clock domain.
//   Synchronises the asynchronous SPI pins and deserialises each chip-select frame into WORD_WIDTH words.
//   Emits one strobe per word and one status strobe per frame for the job loader.
// PARAMETERS
//   SYNC_STAGES  2   flip-flop stages on each SPI pin; legal values are 2 and 3
//   WORD_WIDTH   32  bits per output word
//   MAX_WORDS    16  maximum words per frame; the job is 512 header bits
//   IDX_WIDTH    4   width of word_index_out; equals clog2(MAX_WORDS)
// PORTS
//   clk_in            in   1           PLL global clock; all logic is on its rising edge
//   reset_in          in   1           asynchronous, active-high reset
//   sck_in            in   1           SPI clock, asynchronous; must be <= clk_in/4
//   sdi_in            in   1           SPI data, asynchronous
//   cs_n_in           in   1           SPI chip select, asynchronous, active-low
//   word_out          out  WORD_WIDTH  last completed word, MSB = first bit received
//   word_valid_out    out  1           1-cycle strobe: word_out/word_index_out are valid
//   word_index_out    out  IDX_WIDTH   position of the word within its frame, starting at 0
//   frame_start_out   out  1           1-cycle strobe on a qualified cs_n falling edge
//   frame_done_out    out  1           1-cycle strobe at the end of a frame
//   frame_error_out   out  1           qualifies frame_done_out: 1 = malformed frame
//   busy_out          out  1           1 while in the SHIFT state
// BEHAVIOUR
//   Reset
//     - All outputs go to 0.
//     - Synchroniser flops reset to idle levels: sck=0, sdi=0, cs_n=1.
//     - Bit and word counters clear; the FSM goes to ARM.
//   Synchronisation
//     - Each pin passes through SYNC_STAGES flops, then one more flop for edge detection.
//     - sck rising edge  = sync_sck & ~prev_sck.
//     - sdi is sampled from the same-depth synced sdi in that same cycle.
//   FSM
//     - ARM   : wait for synced cs_n == 1, then go to IDLE.
//               A reset released mid-frame therefore ignores the remainder of that frame.
//     - IDLE  : on cs_n falling edge -> pulse frame_start_out, clear counters, go to SHIFT.
//     - SHIFT : on each sck rise, shift sdi into shreg LSB and increment bit_cnt.
//               When bit_cnt wraps at WORD_WIDTH:
//                 * if word_cnt < MAX_WORDS: word_out <= shreg, pulse word_valid_out,
//                   word_index_out <= word_cnt.
//                 * otherwise: discard the word and set the ovf sticky flag.
//                 * word_cnt increments, saturating at MAX_WORDS.
//               On cs_n rising edge -> go to DONE.
//     - DONE  : pulse frame_done_out for one cycle, then go to IDLE.
//               frame_error_out = (bit_cnt != 0) | ovf | (word_cnt == 0).
//               frame_error_out is held until the next frame_start_out.
//   Latency
//     - word_valid_out rises exactly SYNC_STAGES+2 clk_in cycles after the pin-level sck
//       rising edge of the word's last bit.
//   Simultaneous events
//     - An sck rise in the same cycle as a cs_n rise is ignored; the frame ends first.
//     - word_valid_out and frame_done_out are never asserted in the same cycle.
//   Other rules
//     - A partial word at frame end is dropped, never emitted, and flagged as an error.
//     - word_out holds its value between strobes.
//     - sck edges while cs_n is high are ignored.
//     - A new cs_n fall in the DONE cycle is accepted on the next cycle; no frame is lost.
// TESTING
//   1. Reset, then cs low, 64 bits 0xDEADBEEF_01234567, cs high
//      -> two strobes: idx0 = 0xDEADBEEF, idx1 = 0x01234567; frame_done with error = 0.
//   2. Frame of 40 bits -> one word strobe (idx0), then frame_done with error = 1.
//      The 8 trailing bits are never emitted.
//   3. Frame of 17 x 32 bits -> 16 strobes with idx 0..15, then frame_done with error = 1.
//   4. Assert reset_in mid-word with cs held low, release, clock more bits, then raise cs
//      -> no word and no frame strobes until a fresh cs fall.
//      The next full frame then completes normally.
//   5. Measure from the last sck edge to word_valid_out at sck = clk/4
//      -> exactly SYNC_STAGES+2 cycles.
//      Bench also checks back-to-back frames with a 1-cycle cs-high gap: both frames are received.
//   6. cs low with no sck, then cs high -> frame_start, then frame_done with error = 1;
//      no word strobes.

Source files
------------

// File: rtl/spi_frame_rx.sv
// Oversampled SPI mode-0 receiver (MSB first) for the global job bus.
// Synchronises the pins and splits each chip-select frame into words with per-frame status.
`timescale 1ns/1ps
module spi_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int WORD_WIDTH  = 32,
  parameter int MAX_WORDS   = 16,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  sck_in,
  input  logic                  sdi_in,
  input  logic                  cs_n_in,
  output logic [WORD_WIDTH-1:0] word_out,
  output logic                  word_valid_out,
  output logic [IDX_WIDTH-1:0]  word_index_out,
  output logic                  frame_start_out,
  output logic                  frame_done_out,
  output logic                  frame_error_out,
  output logic                  busy_out
);
  localparam int BIT_W = $clog2(WORD_WIDTH);
  localparam int CNT_W = IDX_WIDTH + 1;

  typedef enum logic [1:0] {ARM, IDLE, SHIFT, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sck_prev;
  logic                   cs_prev;
  logic                   sync_sck;
  logic                   sync_sdi;
  logic                   sync_cs;
  logic                   sck_rise;
  logic                   cs_rise;
  logic                   cs_fall;
  logic [1:0]             arm_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [CNT_W-1:0]       word_cnt;
  logic [WORD_WIDTH-1:0]  shreg;
  logic                   ovf;
  logic                   word_pend;
  logic                   start_pend;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      sck_sync <= '0;
      sdi_sync <= '0;
      cs_sync  <= '1;
      sck_prev <= 1'b0;
      cs_prev  <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_in};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi_in};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n_in};
      sck_prev <= sync_sck;
      cs_prev  <= sync_cs;
    end
  end

  assign sync_sck = sck_sync[SYNC_STAGES-1];
  assign sync_sdi = sdi_sync[SYNC_STAGES-1];
  assign sync_cs  = cs_sync[SYNC_STAGES-1];
  assign sck_rise = sync_sck & ~sck_prev;
  assign cs_rise  = sync_cs & ~cs_prev;
  assign cs_fall  = cs_prev & ~sync_cs;

  // A completed word is published one cycle after its last bit is shifted in,
  // so a cs rise can never coincide with the word strobe and the done strobe.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state           <= ARM;
      arm_cnt         <= '0;
      bit_cnt         <= '0;
      word_cnt        <= '0;
      shreg           <= '0;
      ovf             <= 1'b0;
      word_pend       <= 1'b0;
      start_pend      <= 1'b0;
      word_out        <= '0;
      word_valid_out  <= 1'b0;
      word_index_out  <= '0;
      frame_start_out <= 1'b0;
      frame_done_out  <= 1'b0;
      frame_error_out <= 1'b0;
      busy_out        <= 1'b0;
    end else begin
      frame_start_out <= 1'b0;
      frame_done_out  <= 1'b0;
      word_valid_out  <= 1'b0;
      word_pend       <= 1'b0;

      if (word_pend) begin
        if (word_cnt < CNT_W'(MAX_WORDS)) begin
          word_out       <= shreg;
          word_valid_out <= 1'b1;
          word_index_out <= word_cnt[IDX_WIDTH-1:0];
          word_cnt       <= word_cnt + 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end

      case (state)
        // Wait for the synchroniser to refill, so a frame in flight at reset is ignored.
        ARM: begin
          if (arm_cnt != 2'(SYNC_STAGES)) begin
            arm_cnt <= arm_cnt + 1'b1;
          end else if (sync_cs) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (cs_fall || start_pend) begin
            start_pend      <= 1'b0;
            frame_start_out <= 1'b1;
            frame_error_out <= 1'b0;
            bit_cnt         <= '0;
            word_cnt        <= '0;
            ovf             <= 1'b0;
            busy_out        <= 1'b1;
            state           <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            busy_out <= 1'b0;
            state    <= DONE;
          end else if (sck_rise) begin
            shreg <= {shreg[WORD_WIDTH-2:0], sync_sdi};
            if (bit_cnt == BIT_W'(WORD_WIDTH - 1)) begin
              bit_cnt   <= '0;
              word_pend <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          frame_done_out  <= 1'b1;
          frame_error_out <= (bit_cnt != '0) | ovf | (word_cnt == '0);
          start_pend      <= cs_fall;
          state           <= IDLE;
        end
        default: state <= ARM;
      endcase
    end
  end

endmodule
